// File: rtl/axi_wr_ctrl.sv
// User-to-AXI write burst master: one request -> AW, awlen+1 W beats, B response.
// A rising edge on wr_req while idle and calibrated starts a burst.
module axi_wr_ctrl #(
   parameter int ADDR_WIDTH = 28,
   parameter int DATA_WIDTH = 256
) (
   input  logic                    clk_100M,
   input  logic                    rst,
   input  logic                    init_done,
   input  logic                    wr_req,
   input  logic [ADDR_WIDTH-1:0]   wr_addr,
   input  logic [3:0]              awlen,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   output logic                    wr_data_req,
   output logic                    wr_busy,
   output logic                    wr_done,
   output logic                    wr_err,
   output logic [ADDR_WIDTH-1:0]   axi_awaddr,
   output logic [3:0]              axi_awlen,
   output logic                    axi_awvalid,
   input  logic                    axi_awready,
   output logic [DATA_WIDTH-1:0]   axi_wdata,
   output logic [DATA_WIDTH/8-1:0] axi_wstrb,
   output logic                    axi_wvalid,
   output logic                    axi_wlast,
   input  logic                    axi_wready,
   input  logic                    axi_bvalid,
   input  logic [1:0]              axi_bresp,
   output logic                    axi_bready
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

   state_t     state;
   logic       wr_req_d;
   logic [3:0] beat_cnt;
   logic       accept;

   assign accept      = wr_req & ~wr_req_d & init_done & (state == IDLE);
   assign wr_data_req = axi_wvalid & axi_wready;
   assign axi_wdata   = wr_data;
   assign axi_wstrb   = '1;
   assign axi_wlast   = axi_wvalid & (beat_cnt == axi_awlen);

   always_ff @(posedge clk_100M or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         wr_req_d    <= 1'b0;
         beat_cnt    <= '0;
         wr_busy     <= 1'b0;
         wr_done     <= 1'b0;
         wr_err      <= 1'b0;
         axi_awaddr  <= '0;
         axi_awlen   <= '0;
         axi_awvalid <= 1'b0;
         axi_wvalid  <= 1'b0;
         axi_bready  <= 1'b0;
      end else begin
         wr_req_d <= wr_req;
         wr_done  <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  state       <= ADDR;
                  axi_awvalid <= 1'b1;
                  wr_busy     <= 1'b1;
                  axi_awaddr  <= wr_addr;
                  axi_awlen   <= awlen;
                  wr_err      <= 1'b0;
                  beat_cnt    <= '0;
               end
            end
            ADDR: begin
               if (axi_awvalid && axi_awready) begin
                  axi_awvalid <= 1'b0;
                  axi_wvalid  <= 1'b1;
                  state       <= DATA;
               end
            end
            DATA: begin
               if (axi_wvalid && axi_wready) begin
                  // Counter returns to 0 on the last beat so it never exceeds awlen.
                  if (axi_wlast) begin
                     beat_cnt   <= '0;
                     axi_wvalid <= 1'b0;
                     axi_bready <= 1'b1;
                     state      <= RESP;
                  end else begin
                     beat_cnt   <= beat_cnt + 4'd1;
                  end
               end
            end
            RESP: begin
               if (axi_bvalid && axi_bready) begin
                  axi_bready <= 1'b0;
                  wr_done    <= 1'b1;
                  wr_busy    <= 1'b0;
                  wr_err     <= (axi_bresp != 2'b00);
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_wr_ctrl.sv
// Directed bench for axi_wr_ctrl: burst timing, back-pressure, dropped requests,
// error response and asynchronous reset mid-burst.
module tb_axi_wr_ctrl;

   localparam int AW = 28;
   localparam int DW = 256;

   logic            clk_100M = 1'b0;
   logic            rst = 1'b1;
   logic            init_done = 1'b0;
   logic            wr_req = 1'b0;
   logic [AW-1:0]   wr_addr = '0;
   logic [3:0]      awlen = '0;
   logic [DW-1:0]   wr_data = '0;
   logic            wr_data_req, wr_busy, wr_done, wr_err;
   logic [AW-1:0]   axi_awaddr;
   logic [3:0]      axi_awlen;
   logic            axi_awvalid;
   logic            axi_awready = 1'b0;
   logic [DW-1:0]   axi_wdata;
   logic [DW/8-1:0] axi_wstrb;
   logic            axi_wvalid, axi_wlast;
   logic            axi_wready = 1'b0;
   logic            axi_bvalid = 1'b0;
   logic [1:0]      axi_bresp = 2'b00;
   logic            axi_bready;

   int unsigned checks = 0;
   int unsigned fails = 0;
   int unsigned burst_base = 0;
   int unsigned beats_seen = 0;
   int unsigned done_cnt = 0;
   int unsigned aw_hs = 0;
   logic [DW-1:0] cap_data[$];
   logic          cap_last[$];

   axi_wr_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk_100M(clk_100M), .rst(rst), .init_done(init_done), .wr_req(wr_req),
      .wr_addr(wr_addr), .awlen(awlen), .wr_data(wr_data), .wr_data_req(wr_data_req),
      .wr_busy(wr_busy), .wr_done(wr_done), .wr_err(wr_err), .axi_awaddr(axi_awaddr),
      .axi_awlen(axi_awlen), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
      .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
      .axi_wlast(axi_wlast), .axi_wready(axi_wready), .axi_bvalid(axi_bvalid),
      .axi_bresp(axi_bresp), .axi_bready(axi_bready)
   );

   always #5 clk_100M = ~clk_100M;

   // Passive record of W beats, B completions and AW handshakes.
   always @(posedge clk_100M) begin
      if (!rst) begin
         if (wr_data_req) begin
            cap_data.push_back(axi_wdata);
            cap_last.push_back(axi_wlast);
            beats_seen <= beats_seen + 1;
         end
         if (wr_done) done_cnt <= done_cnt + 1;
         if (axi_awvalid && axi_awready) aw_hs <= aw_hs + 1;
      end
   end

   function automatic logic [DW-1:0] mk_data(input int unsigned i);
      return {8{32'hC0DE0000 + i}};
   endfunction

   // Advance one clock; user side presents the next beat after each accepted one.
   task automatic cycle();
      @(posedge clk_100M);
      #1;
      wr_data = mk_data(beats_seen - burst_base);
      #1;
   endtask

   task automatic wait_done(input int unsigned max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < int'(max) && !ok; i++) begin
         cycle();
         if (wr_done) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      cycle();
      cycle();
      checks++;
      if ({axi_awvalid, axi_wvalid, axi_bready, wr_busy, wr_done, wr_err, wr_data_req, axi_wlast} !== 8'h00) begin
         fails++;
         $display("FAIL reset_ctrl: got %b expected 00000000",
                  {axi_awvalid, axi_wvalid, axi_bready, wr_busy, wr_done, wr_err, wr_data_req, axi_wlast});
      end
      checks++;
      if (axi_awaddr !== '0 || axi_awlen !== 4'd0) begin
         fails++;
         $display("FAIL reset_addr: got %0h/%0h expected 0/0", axi_awaddr, axi_awlen);
      end
      checks++;
      if (axi_wstrb !== {(DW/8){1'b1}}) begin
         fails++;
         $display("FAIL wstrb: got %0h expected all ones", axi_wstrb);
      end
      rst = 1'b0;
      init_done = 1'b1;
      axi_awready = 1'b1;
      axi_wready = 1'b1;
      axi_bvalid = 1'b1;
      cycle();
   endtask

   task automatic test_single_beat();
      int unsigned dn;
      burst_base = beats_seen;
      dn = done_cnt;
      wr_addr = 28'h0000100;
      awlen = 4'd0;
      wr_req = 1'b1;
      cycle();
      checks++;
      if (!(axi_awvalid === 1'b1 && axi_awaddr === 28'h0000100 && axi_awlen === 4'd0 && wr_busy === 1'b1 && axi_wvalid === 1'b0)) begin
         fails++;
         $display("FAIL single_aw: got awv=%b addr=%0h len=%0h busy=%b wv=%b expected 1 100 0 1 0",
                  axi_awvalid, axi_awaddr, axi_awlen, wr_busy, axi_wvalid);
      end
      wr_req = 1'b0;
      cycle();
      checks++;
      if (!(axi_awvalid === 1'b0 && axi_wvalid === 1'b1 && axi_wlast === 1'b1 && wr_data_req === 1'b1)) begin
         fails++;
         $display("FAIL single_w: got awv=%b wv=%b wl=%b req=%b expected 0 1 1 1",
                  axi_awvalid, axi_wvalid, axi_wlast, wr_data_req);
      end
      checks++;
      if (axi_wdata !== mk_data(0)) begin
         fails++;
         $display("FAIL single_wdata: got %0h expected %0h", axi_wdata, mk_data(0));
      end
      cycle();
      checks++;
      if (!(axi_wvalid === 1'b0 && axi_bready === 1'b1 && beats_seen - burst_base == 1 && wr_done === 1'b0)) begin
         fails++;
         $display("FAIL single_resp: got wv=%b br=%b beats=%0d done=%b expected 0 1 1 0",
                  axi_wvalid, axi_bready, beats_seen - burst_base, wr_done);
      end
      cycle();
      checks++;
      if (!(wr_done === 1'b1 && wr_busy === 1'b0 && axi_bready === 1'b0 && wr_err === 1'b0)) begin
         fails++;
         $display("FAIL single_done: got done=%b busy=%b br=%b err=%b expected 1 0 0 0",
                  wr_done, wr_busy, axi_bready, wr_err);
      end
      cycle();
      checks++;
      if (wr_done !== 1'b0 || done_cnt - dn != 1) begin
         fails++;
         $display("FAIL single_done_once: got done=%b count=%0d expected 0 1", wr_done, done_cnt - dn);
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      burst_base = beats_seen;
      wr_addr = 28'h0000200;
      awlen = 4'd0;
      wr_req = 1'b1;
      cycle();
      wr_req = 1'b0;
      wait_done(10, ok);
      checks++;
      if (!ok) begin
         fails++;
         $display("FAIL b2b_first_done: got timeout expected wr_done");
      end
      burst_base = beats_seen;
      wr_addr = 28'h0000240;
      wr_req = 1'b1;
      cycle();
      checks++;
      if (!(axi_awvalid === 1'b1 && axi_awaddr === 28'h0000240)) begin
         fails++;
         $display("FAIL b2b_accept: got awv=%b addr=%0h expected 1 240", axi_awvalid, axi_awaddr);
      end
      wr_req = 1'b0;
      wait_done(10, ok);
      checks++;
      if (!ok) begin
         fails++;
         $display("FAIL b2b_second_done: got timeout expected wr_done");
      end
   endtask

   task automatic test_wready_pattern();
      bit ok;
      int unsigned bad_data, bad_last;
      burst_base = beats_seen;
      wr_addr = 28'h0002000;
      awlen = 4'd15;
      wr_req = 1'b1;
      cycle();
      wr_req = 1'b0;
      cycle();
      for (int i = 0; i < 64 && axi_bready !== 1'b1; i++) begin
         axi_wready = (i % 2 == 0);
         cycle();
      end
      axi_wready = 1'b1;
      checks++;
      if (beats_seen - burst_base != 16) begin
         fails++;
         $display("FAIL pattern_beats: got %0d expected 16", beats_seen - burst_base);
      end
      bad_data = 0;
      bad_last = 0;
      for (int k = 0; k < 16 && burst_base + k < cap_data.size(); k++) begin
         if (cap_data[burst_base + k] !== mk_data(k)) bad_data++;
         if (cap_last[burst_base + k] !== (k == 15)) bad_last++;
      end
      checks++;
      if (bad_data != 0) begin
         fails++;
         $display("FAIL pattern_data_order: got %0d wrong beats expected 0", bad_data);
      end
      checks++;
      if (bad_last != 0) begin
         fails++;
         $display("FAIL pattern_wlast: got %0d misplaced wlast expected 0", bad_last);
      end
      wait_done(10, ok);
      checks++;
      if (!ok) begin
         fails++;
         $display("FAIL pattern_done: got timeout expected wr_done");
      end
   endtask

   task automatic test_aw_stall();
      bit ok, stable;
      burst_base = beats_seen;
      axi_awready = 1'b0;
      wr_addr = 28'h0ABCDE0;
      awlen = 4'd1;
      wr_req = 1'b1;
      cycle();
      wr_req = 1'b0;
      stable = 1'b1;
      for (int k = 0; k < 5; k++) begin
         if (!(axi_awvalid === 1'b1 && axi_awaddr === 28'h0ABCDE0 && axi_awlen === 4'd1 && axi_wvalid === 1'b0))
            stable = 1'b0;
         cycle();
      end
      checks++;
      if (!stable) begin
         fails++;
         $display("FAIL aw_stall_stable: got unstable awv=%b addr=%0h wv=%b expected held",
                  axi_awvalid, axi_awaddr, axi_wvalid);
      end
      axi_awready = 1'b1;
      cycle();
      checks++;
      if (!(axi_awvalid === 1'b0 && axi_wvalid === 1'b1)) begin
         fails++;
         $display("FAIL aw_stall_release: got awv=%b wv=%b expected 0 1", axi_awvalid, axi_wvalid);
      end
      wait_done(10, ok);
      checks++;
      if (!ok || beats_seen - burst_base != 2) begin
         fails++;
         $display("FAIL aw_stall_done: got ok=%b beats=%0d expected 1 2", ok, beats_seen - burst_base);
      end
   endtask

   task automatic test_ignored_requests();
      bit ok;
      int unsigned aw0;
      aw0 = aw_hs;
      burst_base = beats_seen;
      axi_wready = 1'b0;
      wr_addr = 28'h0000300;
      awlen = 4'd3;
      wr_req = 1'b1;
      cycle();
      wr_req = 1'b0;
      cycle();
      cycle();
      wr_req = 1'b1;
      cycle();
      init_done = 1'b0;
      cycle();
      checks++;
      if (!(axi_wvalid === 1'b1 && axi_awvalid === 1'b0 && wr_busy === 1'b1)) begin
         fails++;
         $display("FAIL ignore_in_data: got wv=%b awv=%b busy=%b expected 1 0 1", axi_wvalid, axi_awvalid, wr_busy);
      end
      axi_wready = 1'b1;
      wait_done(12, ok);
      checks++;
      if (!ok || beats_seen - burst_base != 4) begin
         fails++;
         $display("FAIL ignore_burst_done: got ok=%b beats=%0d expected 1 4", ok, beats_seen - burst_base);
      end
      cycle();
      cycle();
      checks++;
      if (wr_busy !== 1'b0 || axi_awvalid !== 1'b0) begin
         fails++;
         $display("FAIL ignore_level_high: got busy=%b awv=%b expected 0 0", wr_busy, axi_awvalid);
      end
      wr_req = 1'b0;
      cycle();
      wr_req = 1'b1;
      cycle();
      cycle();
      checks++;
      if (wr_busy !== 1'b0 || axi_awvalid !== 1'b0) begin
         fails++;
         $display("FAIL ignore_no_init: got busy=%b awv=%b expected 0 0", wr_busy, axi_awvalid);
      end
      wr_req = 1'b0;
      init_done = 1'b1;
      cycle();
      cycle();
      checks++;
      if (aw_hs - aw0 != 1) begin
         fails++;
         $display("FAIL ignore_aw_count: got %0d expected 1", aw_hs - aw0);
      end
   endtask

   task automatic test_error_resp();
      bit ok;
      burst_base = beats_seen;
      axi_bvalid = 1'b0;
      wr_addr = 28'h0000500;
      awlen = 4'd0;
      wr_req = 1'b1;
      cycle();
      wr_req = 1'b0;
      for (int i = 0; i < 10 && axi_bready !== 1'b1; i++) cycle();
      checks++;
      if (axi_bready !== 1'b1) begin
         fails++;
         $display("FAIL err_bready: got %b expected 1", axi_bready);
      end
      axi_bvalid = 1'b1;
      axi_bresp = 2'b10;
      cycle();
      checks++;
      if (!(wr_done === 1'b1 && wr_err === 1'b1)) begin
         fails++;
         $display("FAIL err_set: got done=%b err=%b expected 1 1", wr_done, wr_err);
      end
      axi_bvalid = 1'b0;
      axi_bresp = 2'b00;
      cycle();
      checks++;
      if (!(wr_done === 1'b0 && wr_err === 1'b1)) begin
         fails++;
         $display("FAIL err_held: got done=%b err=%b expected 0 1", wr_done, wr_err);
      end
      burst_base = beats_seen;
      wr_req = 1'b1;
      cycle();
      checks++;
      if (!(wr_err === 1'b0 && wr_busy === 1'b1)) begin
         fails++;
         $display("FAIL err_clear: got err=%b busy=%b expected 0 1", wr_err, wr_busy);
      end
      wr_req = 1'b0;
      axi_bvalid = 1'b1;
      wait_done(10, ok);
      checks++;
      if (!ok || wr_err !== 1'b0) begin
         fails++;
         $display("FAIL err_okay_resp: got ok=%b err=%b expected 1 0", ok, wr_err);
      end
   endtask

   task automatic test_reset_mid_burst();
      bit ok;
      burst_base = beats_seen;
      wr_addr = 28'h0000600;
      awlen = 4'd7;
      wr_req = 1'b1;
      cycle();
      wr_req = 1'b0;
      for (int i = 0; i < 20 && beats_seen - burst_base < 3; i++) cycle();
      checks++;
      if (beats_seen - burst_base != 3 || axi_wvalid !== 1'b1) begin
         fails++;
         $display("FAIL rst_mid_setup: got beats=%0d wv=%b expected 3 1", beats_seen - burst_base, axi_wvalid);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({axi_awvalid, axi_wvalid, axi_bready, wr_busy, wr_done, wr_err, wr_data_req, axi_wlast} !== 8'h00) begin
         fails++;
         $display("FAIL rst_mid_async: got %b expected 00000000",
                  {axi_awvalid, axi_wvalid, axi_bready, wr_busy, wr_done, wr_err, wr_data_req, axi_wlast});
      end
      checks++;
      if (axi_awaddr !== '0 || axi_awlen !== 4'd0) begin
         fails++;
         $display("FAIL rst_mid_addr: got %0h/%0h expected 0/0", axi_awaddr, axi_awlen);
      end
      cycle();
      cycle();
      rst = 1'b0;
      cycle();
      checks++;
      if (wr_busy !== 1'b0 || axi_awvalid !== 1'b0) begin
         fails++;
         $display("FAIL rst_mid_idle: got busy=%b awv=%b expected 0 0", wr_busy, axi_awvalid);
      end
      burst_base = beats_seen;
      wr_addr = 28'h0000700;
      awlen = 4'd2;
      wr_req = 1'b1;
      cycle();
      wr_req = 1'b0;
      wait_done(12, ok);
      checks++;
      if (!ok || beats_seen - burst_base != 3 || axi_awaddr !== 28'h0000700) begin
         fails++;
         $display("FAIL rst_mid_fresh: got ok=%b beats=%0d addr=%0h expected 1 3 700",
                  ok, beats_seen - burst_base, axi_awaddr);
      end
      checks++;
      if (beats_seen < 3 || cap_last[beats_seen - 1] !== 1'b1 || cap_last[beats_seen - 2] !== 1'b0) begin
         fails++;
         $display("FAIL rst_mid_wlast: got last flags wrong expected only final beat");
      end
   endtask

   initial begin
      test_reset();
      test_single_beat();
      test_back_to_back();
      test_wready_pattern();
      test_aw_stall();
      test_ignored_requests();
      test_error_resp();
      test_reset_mid_burst();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation time limit");
   end

endmodule
